// File: rtl/exc_track_pipe_pkg.sv
// Shared exception-tracking definitions: ExcCode values and stage flag layout.
package exc_track_pipe_pkg;

    localparam int unsigned EXC_CODE_W = 5;

    typedef enum logic [EXC_CODE_W-1:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Single-bit part of a stage bundle; pc and code travel beside it at
    // their parametrised widths.
    typedef struct packed {
        logic v;    // stage holds a real instruction
        logic bd;   // instruction sits in a branch delay slot
        logic ev;   // an exception is already carried
    } stage_flags_t;

endpackage

// File: rtl/exc_stage_reg.sv
// One tracked pipeline stage: holds, bubbles, flushes and merges detections.
module exc_stage_reg
    import exc_track_pipe_pkg::*;
#(
    parameter int unsigned EXC_W  = 5,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_i,
    input  logic                hold_i,
    input  logic                bubble_i,
    input  stage_flags_t        ld_flags_i,
    input  logic [ADDR_W-1:0]   ld_pc_i,
    input  logic [EXC_W-1:0]    ld_ec_i,
    input  logic                det_v_i,
    input  logic [EXC_W-1:0]    det_exc_i,
    output stage_flags_t        flags_o,
    output logic [ADDR_W-1:0]   pc_o,
    output logic                ev_m_o,
    output logic [EXC_W-1:0]    ec_m_o
);

    stage_flags_t        flags_q, flags_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [EXC_W-1:0]    ec_q, ec_d;

    // Merged view: a carried exception always beats a fresh detection here.
    always_comb begin
        ev_m_o = flags_q.ev | det_v_i;
        ec_m_o = flags_q.ev ? ec_q : det_exc_i;
    end

    // Next state: flush beats hold; a bubble only enters an unheld stage.
    always_comb begin
        flags_d = flags_q;
        pc_d    = pc_q;
        ec_d    = ec_q;
        if (flush_i) begin
            flags_d.v  = 1'b0;
            flags_d.ev = 1'b0;
        end else if (!hold_i) begin
            if (bubble_i) begin
                flags_d.v  = 1'b0;
                flags_d.ev = 1'b0;
            end else begin
                flags_d = ld_flags_i;
                pc_d    = ld_pc_i;
                ec_d    = ld_ec_i;
            end
        end
    end

    // Stage state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
            pc_q    <= '0;
            ec_q    <= '0;
        end else begin
            flags_q <= flags_d;
            pc_q    <= pc_d;
            ec_q    <= ec_d;
        end
    end

    assign flags_o = flags_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/exc_track_pipe.sv
// Exception state tracker for NSTG pipeline stages with precise commit,
// EPC/code/BD capture and an EXL lock released by ERET.
module exc_track_pipe
    import exc_track_pipe_pkg::*;
#(
    parameter int unsigned NSTG     = 3,
    parameter int unsigned EXC_W    = 5,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INT_CODE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSTG-1:0]         stall_i,
    input  logic                    in_valid,
    input  logic [ADDR_W-1:0]       in_pc,
    input  logic                    in_bd,
    input  logic                    in_exc_v,
    input  logic [EXC_W-1:0]        in_exc,
    input  logic [NSTG-1:0]         det_v,
    input  logic [NSTG*EXC_W-1:0]   det_exc,
    input  logic                    int_req,
    input  logic                    eret_i,
    output logic                    flush_o,
    output logic                    exc_req,
    output logic [EXC_W-1:0]        exc_code,
    output logic [ADDR_W-1:0]       epc,
    output logic                    exc_bd,
    output logic                    exl
);

    localparam int unsigned L = NSTG - 1;

    stage_flags_t        flags_s    [NSTG];
    stage_flags_t        ld_flags_s [NSTG];
    logic [ADDR_W-1:0]   pc_s       [NSTG];
    logic [ADDR_W-1:0]   ld_pc_s    [NSTG];
    logic [EXC_W-1:0]    ec_m_s     [NSTG];
    logic [EXC_W-1:0]    ld_ec_s    [NSTG];
    logic [NSTG-1:0]     ev_m_s;
    logic [NSTG-1:0]     bubble_s;
    logic [NSTG-1:0]     v_s;

    logic                take;
    logic                exc_req_q, exl_q, exl_d, exc_bd_q, exc_bd_d;
    logic [EXC_W-1:0]    exc_code_q, exc_code_d;
    logic [ADDR_W-1:0]   epc_q, epc_d;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        if (k == 0) begin : g_head
            assign ld_flags_s[k] = '{v: in_valid, bd: in_bd, ev: in_exc_v};
            assign ld_pc_s[k]    = in_pc;
            assign ld_ec_s[k]    = in_exc;
            assign bubble_s[k]   = 1'b0;
        end else begin : g_body
            assign ld_flags_s[k] = '{v: flags_s[k-1].v, bd: flags_s[k-1].bd, ev: ev_m_s[k-1]};
            assign ld_pc_s[k]    = pc_s[k-1];
            assign ld_ec_s[k]    = ec_m_s[k-1];
            assign bubble_s[k]   = stall_i[k-1];
        end

        exc_stage_reg #(
            .EXC_W  (EXC_W),
            .ADDR_W (ADDR_W)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush_i    (take),
            .hold_i     (stall_i[k]),
            .bubble_i   (bubble_s[k]),
            .ld_flags_i (ld_flags_s[k]),
            .ld_pc_i    (ld_pc_s[k]),
            .ld_ec_i    (ld_ec_s[k]),
            .det_v_i    (det_v[k]),
            .det_exc_i  (det_exc[k*EXC_W +: EXC_W]),
            .flags_o    (flags_s[k]),
            .pc_o       (pc_s[k]),
            .ev_m_o     (ev_m_s[k]),
            .ec_m_o     (ec_m_s[k])
        );

        assign v_s[k] = flags_s[k].v;
    end

    // Commit decision and the values captured when an exception is taken.
    always_comb begin
        take       = !exl_q & flags_s[L].v & (int_req | ev_m_s[L]);
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        exc_bd_d   = exc_bd_q;
        exl_d      = exl_q;
        if (take) begin
            exc_code_d = int_req ? EXC_W'(INT_CODE) : ec_m_s[L];
            epc_d      = flags_s[L].bd ? (pc_s[L] - ADDR_W'(4)) : pc_s[L];
            exc_bd_d   = flags_s[L].bd;
            exl_d      = 1'b1;
        end else if (eret_i) begin
            exl_d      = 1'b0;
        end
    end

    // Exception report registers and EXL lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_req_q  <= 1'b0;
            exc_code_q <= '0;
            epc_q      <= '0;
            exc_bd_q   <= 1'b0;
            exl_q      <= 1'b0;
        end else begin
            exc_req_q  <= take;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            exc_bd_q   <= exc_bd_d;
            exl_q      <= exl_d;
        end
    end

    assign flush_o  = take;
    assign exc_req  = exc_req_q;
    assign exc_code = exc_code_q;
    assign epc      = epc_q;
    assign exc_bd   = exc_bd_q;
    assign exl      = exl_q;

endmodule

// File: tb/tb_exc_track_pipe.sv
// Scenario bench for exc_track_pipe (NSTG=3) with an exception scoreboard.
module tb_exc_track_pipe;

    localparam int unsigned NSTG = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NSTG-1:0]   stall_i;
    logic              in_valid;
    logic [31:0]       in_pc;
    logic              in_bd;
    logic              in_exc_v;
    logic [4:0]        in_exc;
    logic [NSTG-1:0]   det_v;
    logic [NSTG*5-1:0] det_exc;
    logic              int_req;
    logic              eret_i;
    logic              flush_o;
    logic              exc_req;
    logic [4:0]        exc_code;
    logic [31:0]       epc;
    logic              exc_bd;
    logic              exl;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    exc_track_pipe #(
        .NSTG     (NSTG),
        .EXC_W    (5),
        .ADDR_W   (32),
        .INT_CODE (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall_i  (stall_i),
        .in_valid (in_valid),
        .in_pc    (in_pc),
        .in_bd    (in_bd),
        .in_exc_v (in_exc_v),
        .in_exc   (in_exc),
        .det_v    (det_v),
        .det_exc  (det_exc),
        .int_req  (int_req),
        .eret_i   (eret_i),
        .flush_o  (flush_o),
        .exc_req  (exc_req),
        .exc_code (exc_code),
        .epc      (epc),
        .exc_bd   (exc_bd),
        .exl      (exl)
    );

    // Scoreboard: every exc_req pulse must match the oldest expected record.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && exc_req === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: exc_req=1 code=%0d epc=%h bd=%b, none expected",
                         exc_code, epc, exc_bd);
            end else begin
                e = sb_q.pop_front();
                if (exc_code !== e.code || epc !== e.epc || exc_bd !== e.bd || exl !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sb_report: code=%0d epc=%h bd=%b exl=%b, want code=%0d epc=%h bd=%b exl=1",
                             exc_code, epc, exc_bd, exl, e.code, e.epc, e.bd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        stall_i  = '0;
        in_valid = 1'b0;
        in_pc    = '0;
        in_bd    = 1'b0;
        in_exc_v = 1'b0;
        in_exc   = '0;
        det_v    = '0;
        det_exc  = '0;
        eret_i   = 1'b0;
    endtask

    task automatic push(input logic [4:0] c, input logic [31:0] p, input logic b);
        exp_t e;
        e.code = c;
        e.epc  = p;
        e.bd   = b;
        sb_q.push_back(e);
    endtask

    task automatic do_eret();
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        n_checks++;
        if (exl !== 1'b0) begin
            n_fail++;
            $display("FAIL eret_clear: exl=%b want 0", exl);
        end
    endtask

    task automatic test_reset();
        clear_in();
        int_req = 1'b0;
        reset   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
        n_checks++;
        if ({exc_req, exc_code, epc, exc_bd, exl, flush_o, dut.v_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b code=%0d epc=%h bd=%b exl=%b flush=%b v=%b want all 0",
                     exc_req, exc_code, epc, exc_bd, exl, flush_o, dut.v_s);
        end
    endtask

    task automatic test_ov_detect();
        clear_in();
        in_valid = 1'b1;
        in_pc    = 32'h3010;
        tick();
        in_valid = 1'b0;
        tick();
        det_v          = 3'b010;
        det_exc[5 +: 5] = 5'd12;
        settle();
        n_checks++;
        if (flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ov_early_flush: flush_o=%b want 0", flush_o);
        end
        tick();
        det_v = '0;
        settle();
        n_checks++;
        if (flush_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ov_flush: flush_o=%b want 1", flush_o);
        end
        push(5'd12, 32'h3010, 1'b0);
        tick();
        n_checks++;
        if (exc_req !== 1'b1 || exl !== 1'b1 || dut.v_s !== 3'b000 || flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ov_take: req=%b exl=%b v=%b flush=%b want 1 1 000 0",
                     exc_req, exl, dut.v_s, flush_o);
        end
        tick();
        n_checks++;
        if (exc_req !== 1'b0 || exc_code !== 5'd12) begin
            n_fail++;
            $display("FAIL ov_pulse: req=%b code=%0d want 0 12", exc_req, exc_code);
        end
        do_eret();
    endtask

    task automatic test_fetch_priority();
        clear_in();
        in_valid = 1'b1;
        in_pc    = 32'h3004;
        in_exc_v = 1'b1;
        in_exc   = 5'd4;
        tick();
        clear_in();
        tick();
        det_v           = 3'b010;
        det_exc[5 +: 5] = 5'd12;
        tick();
        det_v = '0;
        settle();
        n_checks++;
        if (flush_o !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_flush: flush_o=%b want 1", flush_o);
        end
        push(5'd4, 32'h3004, 1'b0);
        tick();
        n_checks++;
        if (exc_code !== 5'd4) begin
            n_fail++;
            $display("FAIL prio_code: exc_code=%0d want 4", exc_code);
        end
        do_eret();
    endtask

    task automatic test_delay_slot();
        clear_in();
        in_valid = 1'b1;
        in_pc    = 32'h3008;
        in_bd    = 1'b1;
        tick();
        clear_in();
        tick();
        tick();
        det_v            = 3'b100;
        det_exc[10 +: 5] = 5'd10;
        in_valid = 1'b1;
        in_pc    = 32'h3100;
        settle();
        n_checks++;
        if (flush_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bd_flush: flush_o=%b want 1", flush_o);
        end
        push(5'd10, 32'h3004, 1'b1);
        tick();
        clear_in();
        n_checks++;
        if (exc_req !== 1'b1 || epc !== 32'h3004 || exc_bd !== 1'b1 || dut.v_s !== 3'b000) begin
            n_fail++;
            $display("FAIL bd_take: req=%b epc=%h bd=%b v=%b want 1 3004 1 000",
                     exc_req, epc, exc_bd, dut.v_s);
        end
        do_eret();
    endtask

    task automatic test_interrupt();
        clear_in();
        in_valid = 1'b1;
        in_pc    = 32'h3020;
        tick();
        in_valid = 1'b0;
        tick();
        int_req = 1'b1;
        settle();
        n_checks++;
        if (flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL int_bubble: flush_o=%b want 0", flush_o);
        end
        tick();
        n_checks++;
        if (flush_o !== 1'b1) begin
            n_fail++;
            $display("FAIL int_flush: flush_o=%b want 1", flush_o);
        end
        push(5'd0, 32'h3020, 1'b0);
        tick();
        n_checks++;
        if (exc_req !== 1'b1 || exc_code !== 5'd0 || epc !== 32'h3020 || exl !== 1'b1) begin
            n_fail++;
            $display("FAIL int_take: req=%b code=%0d epc=%h exl=%b want 1 0 3020 1",
                     exc_req, exc_code, epc, exl);
        end
        in_valid = 1'b1;
        in_pc    = 32'h3030;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL int_exl_lock: flush_o=%b want 0", flush_o);
        end
        tick();
        n_checks++;
        if (exc_req !== 1'b0 || dut.v_s !== 3'b000) begin
            n_fail++;
            $display("FAIL int_exl_retire: req=%b v=%b want 0 000", exc_req, dut.v_s);
        end
        do_eret();
        settle();
        n_checks++;
        if (flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL int_wait_valid: flush_o=%b want 0", flush_o);
        end
        in_valid = 1'b1;
        in_pc    = 32'h3040;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (flush_o !== 1'b1) begin
            n_fail++;
            $display("FAIL int_retake_flush: flush_o=%b want 1", flush_o);
        end
        push(5'd0, 32'h3040, 1'b0);
        tick();
        int_req = 1'b0;
        n_checks++;
        if (exc_req !== 1'b1 || epc !== 32'h3040) begin
            n_fail++;
            $display("FAIL int_retake: req=%b epc=%h want 1 3040", exc_req, epc);
        end
        do_eret();
    endtask

    task automatic test_stall();
        clear_in();
        in_valid = 1'b1;
        in_pc    = 32'h304c;
        tick();
        in_pc = 32'h3050;
        tick();
        in_valid = 1'b0;
        tick();
        stall_i         = 3'b011;
        det_v           = 3'b010;
        det_exc[5 +: 5] = 5'd12;
        settle();
        n_checks++;
        if (flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_clean_commit: flush_o=%b want 0", flush_o);
        end
        for (int unsigned i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (flush_o !== 1'b0 || exc_req !== 1'b0 || dut.v_s[2:1] !== 2'b01) begin
                n_fail++;
                $display("FAIL stall_hold%0d: flush=%b req=%b v=%b want 0 0 01x",
                         i, flush_o, exc_req, dut.v_s);
            end
        end
        stall_i = '0;
        tick();
        det_v = '0;
        settle();
        n_checks++;
        if (flush_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release_flush: flush_o=%b want 1", flush_o);
        end
        push(5'd12, 32'h3050, 1'b0);
        tick();
        n_checks++;
        if (exc_req !== 1'b1 || exc_code !== 5'd12) begin
            n_fail++;
            $display("FAIL stall_take: req=%b code=%0d want 1 12", exc_req, exc_code);
        end
        do_eret();
    endtask

    task automatic test_reset_during_flush();
        clear_in();
        in_valid = 1'b1;
        in_pc    = 32'h3060;
        in_exc_v = 1'b1;
        in_exc   = 5'd5;
        tick();
        clear_in();
        tick();
        tick();
        n_checks++;
        if (flush_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_flush: flush_o=%b want 1", flush_o);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        n_checks++;
        if ({exc_req, exc_code, epc, exc_bd, exl, flush_o, dut.v_s} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_flush: req=%b code=%0d epc=%h bd=%b exl=%b flush=%b v=%b want all 0",
                     exc_req, exc_code, epc, exc_bd, exl, flush_o, dut.v_s);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_ov_detect();
        test_fetch_priority();
        test_delay_slot();
        test_interrupt();
        test_stall();
        test_reset_during_flush();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected exceptions never reported, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_track_pipe.md
Name: exc_track_pipe

Overview:
- Parametrised successor to the per-stage exception-code selector in the MIPS pipeline.
- Carries exception state (valid, code, PC, branch-delay flag) alongside each instruction through NSTG pipeline stages, merging newly detected exceptions by first-detected-wins priority.
- At the last (commit) stage, raises a precise exception or interrupt: flushes the pipe, latches EPC/code/BD, and holds an EXL lock until ERET.
- Sits beside the D/E/M pipeline registers; the CP0 and PC-select logic consume its outputs.

Parameters:
NSTG, 3, number of tracked stages (index 0 = D, NSTG-1 = commit stage M); minimum 2
EXC_W, 5, ExcCode width
ADDR_W, 32, PC width
INT_CODE, 0, ExcCode reported for interrupts

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
stall_i  in  NSTG  stall_i[k]=1 holds stage k; must be monotonic (stall_i[k+1] implies stall_i[k])
in_valid  in  1  instruction entering stage 0
in_pc  in  ADDR_W  PC of entering instruction
in_bd  in  1  entering instruction is in a delay slot
in_exc_v  in  1  fetch-detected exception (e.g. AdEL on fetch)
in_exc  in  EXC_W  fetch exception code
det_v  in  NSTG  per-stage combinational detection valid for current stage contents
det_exc  in  NSTG*EXC_W  per-stage detected code, slice k = [k*EXC_W +: EXC_W]
int_req  in  1  masked external interrupt pending
eret_i  in  1  ERET committing; clears EXL
flush_o  out  1  combinational: commit condition true this cycle; host flushes its stage registers at this edge
exc_req  out  1  registered one-cycle pulse: exception taken
exc_code  out  EXC_W  latched code of taken exception
epc  out  ADDR_W  latched EPC
exc_bd  out  1  latched BD flag
exl  out  1  exception level lock

Behaviour:
- Stage k state: v, pc, bd, ev, ec. Merged view: ev_m = ev | det_v[k]; ec_m = ev ? ec : det_exc[k]. An already-carried exception always wins over a later-stage detection.
- Advance at each edge:
  - stage k (k>0) loads merged stage k-1 when !stall_i[k].
  - stage k loads a bubble (v=0, ev=0) when stall_i[k-1] & !stall_i[k].
  - stage 0 loads in_* when !stall_i[0].
  - a held stage keeps its contents.
- Commit (combinational, last stage L): take = !exl & v_L & (int_req | ev_m_L). flush_o = take.
- On an edge with take=1:
  - all stage v/ev cleared; overrides stall and discards in_valid.
  - exc_req<=1; exl<=1.
  - exc_code <= int_req ? INT_CODE : ec_m_L (interrupt has priority).
  - epc <= bd_L ? pc_L-4 : pc_L (modulo 2^ADDR_W); exc_bd <= bd_L.
- exc_req is 1 for exactly one cycle; exc_code/epc/exc_bd hold until the next take.
- While exl=1, exceptions and interrupts do not commit: instructions retire normally and their ev is dropped at the last stage.
- eret_i=1 clears exl at the next edge. If eret_i and take coincide, take cannot occur because exl=1.
- An interrupt on a bubble (v_L=0) waits for the next valid instruction at the last stage.
- Reset: all v/ev=0, exc_req=0, exc_code=0, epc=0, exc_bd=0, exl=0. Reset mid-pending discards everything; flush_o follows the cleared state from the next cycle.
- Latency: detection at stage k reaches commit after (NSTG-1-k) unstalled cycles; exc_req follows one edge later.

Decomposition:
- Shared package/header: ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), EXC_W, and the stage state bundle layout.
- One sub-module, exc_stage_reg: a single stage register with merge, hold, bubble, and flush. Instantiate it NSTG times with a generate loop.

Test Plan:
- NSTG=3, addi at pc 0x3010, det_v[1]=1 code 12, no stalls -> flush_o high one cycle later; exc_req=1 next cycle, exc_code=12, epc=0x3010, exc_bd=0, exl=1, all v=0.
- pc 0x3004 enters with in_exc_v=1 code 4, then det_v[1]=1 code 12 on it -> exc_code=4.
- Delay slot pc 0x3008, in_bd=1, det_v[2]=1 code 10 -> epc=0x3004, exc_bd=1.
- int_req=1 with valid pc 0x3020 at stage 2, no sync exception -> exc_code=0, epc=0x3020; int_req held with exl=1 -> no further exc_req until eret_i pulses, then taken on the next valid last-stage instruction.
- Ov pending at stage 1, stall_i=3'b011 for 2 cycles -> bubble in stage 2, flush_o=0, exc_req=0; release -> exc_req two edges later with code 12.
- reset asserted in the same cycle flush_o=1 -> next cycle exc_req=0, exl=0, epc=0, all stages empty.
